// File: rtl/conv_pkg.sv
// conv_pkg: shared helpers for the convolution result path.
//   - o_size / total_words : geometry of the result frame
//   - chan_width           : width of a channel index (at least 1)
//   - state_t              : read-out FSM encoding (IDLE=0, READ=1, DRAIN=2, DONE=3)
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int o_size(input int i_size, input int k_size);
        return i_size - k_size + 1;
    endfunction

    function automatic int total_words(input int i_size, input int k_size, input int k_channels);
        int o;
        o = o_size(i_size, k_size);
        return k_channels * o * o;
    endfunction

    function automatic int chan_width(input int k_channels);
        return (k_channels > 1) ? $clog2(k_channels) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// stream_fifo2: 2-entry synchronous FIFO, head always presented on `head`.
// Ports:
//   clk, rstn        clock, synchronous active-low reset (clears entries and occ)
//   push, push_data  write one entry (caller guarantees room)
//   pop              remove head (ignored when empty)
//   head             oldest entry
//   occ              number of valid entries, 0..2
module stream_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             pop_ok;

    assign pop_ok = pop && (occ != 2'd0);
    assign head   = slot0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= 2'd0;
        end else begin
            if (pop_ok) begin
                // Second entry moves up to the head; a simultaneous push
                // lands directly behind whatever becomes the head.
                if (push) begin
                    if (occ == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end else begin
                    slot0 <= slot1;
                end
            end else if (push) begin
                if (occ == 2'd0) slot0 <= push_data;
                else             slot1 <= push_data;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/conv_result_reader.sv
// conv_result_reader: after start, reads every result word from the result
// BRAM (port A, linear from BASE_ADDR) and streams it out on a valid/ready
// interface tagged with its kernel channel and an end-of-frame marker.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   start                     one-cycle pulse starting a read-out
//   busy, done                busy in READ/DRAIN; done pulses once at the end
//   result_bram_ena/_addra    BRAM read request (one read per ena cycle)
//   result_bram_douta         BRAM read data, one cycle after ena
//   m_data/m_chan/m_last      stream payload (head of the output buffer)
//   m_valid, m_ready          stream handshake
module conv_result_reader
    import conv_pkg::*;
#(
    parameter int I_SIZE      = 24,
    parameter int K_SIZE      = 3,
    parameter int K_CHANNELS  = 16,
    parameter int O_BIT_WIDTH = 16,
    parameter int BASE_ADDR   = 0
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   result_bram_ena,
    output logic [15:0]                            result_bram_addra,
    input  logic [O_BIT_WIDTH-1:0]                 result_bram_douta,
    output logic signed [O_BIT_WIDTH-1:0]          m_data,
    output logic [chan_width(K_CHANNELS)-1:0]      m_chan,
    output logic                                   m_last,
    output logic                                   m_valid,
    input  logic                                   m_ready
);

    localparam int O_SIZE = o_size(I_SIZE, K_SIZE);
    localparam int O_SQ   = O_SIZE * O_SIZE;
    localparam int N      = total_words(I_SIZE, K_SIZE, K_CHANNELS);
    localparam int CW     = chan_width(K_CHANNELS);
    localparam int FW     = O_BIT_WIDTH + CW + 1;

    localparam logic [15:0]   LAST_IDX = 16'(N - 1);
    localparam logic [15:0]   POS_WRAP = 16'(O_SQ - 1);
    localparam logic [CW-1:0] CHAN_ONE = CW'(1);

    if (BASE_ADDR + N > 65536) begin : g_addr_range_chk
        $error("conv_result_reader: BASE_ADDR + N exceeds the 16-bit BRAM address space");
    end

    state_t          state, state_n;
    logic [15:0]     addr;
    logic [15:0]     rd_idx;
    logic [15:0]     pos;
    logic [CW-1:0]   chan;
    logic            inflight;
    logic            infl_last;
    logic [CW-1:0]   infl_chan;
    logic            pop;
    logic [1:0]      occ;
    logic [2:0]      pending;
    logic [FW-1:0]   head;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    // Entries the buffer will hold once this cycle's pop and the in-flight
    // word have both landed; a new read is only issued if it will fit.
    assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign {m_last, m_chan, m_data} = head;
    assign busy              = (state == READ) || (state == DRAIN);
    assign done              = (state == DONE);
    assign result_bram_addra = addr;

    always_comb begin
        state_n         = state;
        result_bram_ena = 1'b0;
        case (state)
            IDLE:  if (start) state_n = READ;
            READ: begin
                if (pending < 3'd2) begin
                    result_bram_ena = 1'b1;
                    if (rd_idx == LAST_IDX) state_n = DRAIN;
                end
            end
            DRAIN: if (pop && m_last) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr      <= 16'(BASE_ADDR);
            rd_idx    <= 16'd0;
            pos       <= 16'd0;
            chan      <= '0;
            inflight  <= 1'b0;
            infl_last <= 1'b0;
            infl_chan <= '0;
        end else begin
            inflight <= result_bram_ena;
            if (state == IDLE && start) begin
                addr   <= 16'(BASE_ADDR);
                rd_idx <= 16'd0;
                pos    <= 16'd0;
                chan   <= '0;
            end else if (result_bram_ena) begin
                // Tags travel with the read so they meet the data on push.
                addr      <= addr + 16'd1;
                rd_idx    <= rd_idx + 16'd1;
                infl_last <= (rd_idx == LAST_IDX);
                infl_chan <= chan;
                if (pos == POS_WRAP) begin
                    pos  <= 16'd0;
                    chan <= chan + CHAN_ONE;
                end else begin
                    pos <= pos + 16'd1;
                end
            end
        end
    end

    stream_fifo2 #(.WIDTH(FW)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_data ({infl_last, infl_chan, result_bram_douta}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench: small frame (5x5 input, 3x3 kernel, 2 channels -> 18 words)
// on instance u_a, default geometry with BASE_ADDR=100 on instance u_b.
module tb_conv_result_reader;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    logic               a_start = 1'b0, a_ready = 1'b0;
    logic               a_busy, a_done, a_ena, a_last, a_valid;
    logic [15:0]        a_addr;
    logic [15:0]        a_douta = 16'd0;
    logic signed [15:0] a_data;
    logic [0:0]         a_chan;

    logic               b_start = 1'b0, b_ready = 1'b0;
    logic               b_busy, b_done, b_ena, b_last, b_valid;
    logic [15:0]        b_addr;
    logic [15:0]        b_douta = 16'd0;
    logic signed [15:0] b_data;
    logic [3:0]         b_chan;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_result_reader #(.I_SIZE(5), .K_SIZE(3), .K_CHANNELS(2), .O_BIT_WIDTH(16), .BASE_ADDR(0)) u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .busy(a_busy), .done(a_done),
        .result_bram_ena(a_ena), .result_bram_addra(a_addr), .result_bram_douta(a_douta),
        .m_data(a_data), .m_chan(a_chan), .m_last(a_last), .m_valid(a_valid), .m_ready(a_ready)
    );

    conv_result_reader #(.BASE_ADDR(100)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .busy(b_busy), .done(b_done),
        .result_bram_ena(b_ena), .result_bram_addra(b_addr), .result_bram_douta(b_douta),
        .m_data(b_data), .m_chan(b_chan), .m_last(b_last), .m_valid(b_valid), .m_ready(b_ready)
    );

    // BRAM models: small frame holds i-9 at index i, large frame holds i.
    always @(posedge clk) if (a_ena) a_douta <= a_addr - 16'd9;
    always @(posedge clk) if (b_ena) b_douta <= b_addr - 16'd100;

    // Monitor for u_a, sampled on the falling edge.
    int cyc = 0, nb = 0, ena_cnt = 0, done_cnt = 0, done_cyc = -1, ena_rise = -1;
    int stab_err = 0, occ_err = 0;
    logic prev_ena = 1'b0, prev_stall = 1'b0, prev_chan = 1'b0, prev_last = 1'b0;
    logic signed [15:0] prev_data = 16'sd0;
    logic signed [15:0] bd [256];
    logic               bc [256];
    logic               bl [256];
    int                 bcy[256];

    always @(negedge clk) begin
        if (rstn) begin
            if (a_valid && a_ready) begin
                if (nb < 256) begin
                    bd[nb] = a_data; bc[nb] = a_chan[0]; bl[nb] = a_last; bcy[nb] = cyc;
                end
                nb++;
            end
            if (a_ena && !prev_ena) ena_rise = cyc;
            if (a_ena) ena_cnt++;
            if (a_done) begin done_cnt++; done_cyc = cyc; end
            if (prev_stall && (!a_valid || a_data !== prev_data || a_chan[0] !== prev_chan || a_last !== prev_last))
                stab_err++;
            if (u_a.u_fifo.occ > 2'd2) occ_err++;
            prev_stall = a_valid && !a_ready;
            prev_ena   = a_ena;
            prev_data  = a_data;
            prev_chan  = a_chan[0];
            prev_last  = a_last;
        end else begin
            prev_stall = 1'b0;
            prev_ena   = 1'b0;
        end
        cyc++;
    end

    task automatic pulse_a;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_busy, a_done, a_ena, a_valid, a_last} !== 5'b0) begin
            bad++; $display("FAIL reset_ctl: got %b want 00000", {a_busy, a_done, a_ena, a_valid, a_last});
        end
        total++;
        if (a_addr !== 16'd0 || a_data !== 16'sd0 || a_chan !== 1'b0) begin
            bad++; $display("FAIL reset_data: addr=%0d data=%0d chan=%0d want 0 0 0", a_addr, a_data, a_chan);
        end
        total++;
        if (b_addr !== 16'd100 || b_valid !== 1'b0 || b_busy !== 1'b0) begin
            bad++; $display("FAIL reset_b: addr=%0d valid=%b busy=%b want 100 0 0", b_addr, b_valid, b_busy);
        end
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_stream;
        int b0, e0, d0, c;
        bit ok;
        a_ready = 1'b1;
        b0 = nb; e0 = ena_cnt; d0 = done_cnt;
        pulse_a();
        c = cyc;
        wait_a_done(d0, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stream_timeout: no done within 100 cycles"); end
        repeat (3) @(posedge clk);
        total++;
        if (nb - b0 !== 18) begin bad++; $display("FAIL stream_beats: got %0d want 18", nb - b0); end
        for (int k = 0; k < 18; k++) begin
            total++;
            if (bd[b0+k] !== 16'(k - 9) || bc[b0+k] !== (k >= 9) || bl[b0+k] !== (k == 17)) begin
                bad++;
                $display("FAIL stream_beat%0d: got d=%0d c=%0d l=%0d want d=%0d c=%0d l=%0d",
                         k, bd[b0+k], bc[b0+k], bl[b0+k], k - 9, (k >= 9), (k == 17));
            end
        end
        total++;
        if (ena_rise !== c) begin bad++; $display("FAIL stream_ena_start: got cycle %0d want %0d", ena_rise, c); end
        total++;
        if (bcy[b0] !== c + 2 || bcy[b0+17] !== c + 19) begin
            bad++; $display("FAIL stream_timing: first=%0d last=%0d want %0d %0d", bcy[b0], bcy[b0+17], c + 2, c + 19);
        end
        total++;
        if (done_cyc !== c + 20 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL stream_done: cyc=%0d n=%0d want %0d 1", done_cyc, done_cnt - d0, c + 20);
        end
        total++;
        if (ena_cnt - e0 !== 18) begin bad++; $display("FAIL stream_ena_count: got %0d want 18", ena_cnt - e0); end
    endtask

    task automatic test_backpressure;
        int b0, d0, s0, i;
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        b0 = nb; d0 = done_cnt; s0 = stab_err;
        a_ready = pat[0];
        pulse_a();
        for (i = 0; i < 300 && done_cnt == d0; i++) begin
            a_ready = pat[i % 6];
            @(posedge clk); #1;
        end
        a_ready = 1'b1;
        total++;
        if (done_cnt == d0) begin bad++; $display("FAIL bp_timeout: no done within 300 cycles"); end
        total++;
        if (nb - b0 !== 18) begin bad++; $display("FAIL bp_beats: got %0d want 18", nb - b0); end
        for (int k = 0; k < 18; k++) begin
            total++;
            if (bd[b0+k] !== 16'(k - 9) || bc[b0+k] !== (k >= 9) || bl[b0+k] !== (k == 17)) begin
                bad++; $display("FAIL bp_beat%0d: got d=%0d c=%0d l=%0d want d=%0d", k, bd[b0+k], bc[b0+k], bl[b0+k], k - 9);
            end
        end
        total++;
        if (stab_err !== s0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stab_err - s0); end
        total++;
        if (occ_err !== 0) begin bad++; $display("FAIL bp_occ: got %0d cycles above 2 want 0", occ_err); end
    endtask

    task automatic test_stall20;
        int b0, e0, d0;
        bit ok;
        a_ready = 1'b0;
        b0 = nb; e0 = ena_cnt; d0 = done_cnt;
        pulse_a();
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (ena_cnt - e0 !== 2) begin bad++; $display("FAIL stall_reads: got %0d want 2", ena_cnt - e0); end
        total++;
        if (a_valid !== 1'b1 || a_data !== -16'sd9) begin
            bad++; $display("FAIL stall_head: valid=%b data=%0d want 1 -9", a_valid, a_data);
        end
        @(posedge clk); #1 a_ready = 1'b1;
        wait_a_done(d0, 100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_timeout: no done after release"); end
        total++;
        if (nb - b0 !== 18) begin bad++; $display("FAIL stall_beats: got %0d want 18", nb - b0); end
        for (int k = 0; k < 18; k++) begin
            total++;
            if (bd[b0+k] !== 16'(k - 9) || bl[b0+k] !== (k == 17)) begin
                bad++; $display("FAIL stall_beat%0d: got d=%0d l=%0d want d=%0d", k, bd[b0+k], bl[b0+k], k - 9);
            end
        end
    endtask

    task automatic test_double_start;
        int b0, e0, d0;
        a_ready = 1'b1;
        b0 = nb; e0 = ena_cnt; d0 = done_cnt;
        pulse_a();
        for (int i = 0; i < 50 && nb - b0 < 5; i++) begin @(posedge clk); #1; end
        pulse_a();
        repeat (60) @(posedge clk);
        #1;
        total++;
        if (nb - b0 !== 18) begin bad++; $display("FAIL dbl_beats: got %0d want 18", nb - b0); end
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL dbl_done: got %0d pulses want 1", done_cnt - d0); end
        total++;
        if (ena_cnt - e0 !== 18) begin bad++; $display("FAIL dbl_reads: got %0d want 18", ena_cnt - e0); end
        total++;
        if (bd[b0+17] !== 16'sd8 || bl[b0+17] !== 1'b1) begin
            bad++; $display("FAIL dbl_last: got d=%0d l=%0d want 8 1", bd[b0+17], bl[b0+17]);
        end
    endtask

    task automatic test_mid_reset;
        int b0, d0;
        bit ok;
        a_ready = 1'b1;
        b0 = nb; d0 = done_cnt;
        pulse_a();
        for (int i = 0; i < 50 && nb - b0 < 7; i++) begin @(posedge clk); #1; end
        total++;
        if (a_ena !== 1'b1 || u_a.inflight !== 1'b1) begin
            bad++; $display("FAIL rst_inflight: ena=%b inflight=%b want 1 1", a_ena, u_a.inflight);
        end
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        total++;
        if ({a_busy, a_done, a_ena, a_valid, a_last} !== 5'b0 || a_addr !== 16'd0 || a_data !== 16'sd0 || a_chan !== 1'b0) begin
            bad++;
            $display("FAIL rst_outputs: ctl=%b addr=%0d data=%0d chan=%0d want 00000 0 0 0",
                     {a_busy, a_done, a_ena, a_valid, a_last}, a_addr, a_data, a_chan);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (done_cnt !== d0 || a_valid !== 1'b0) begin
            bad++; $display("FAIL rst_quiet: done=%0d valid=%b want 0 0", done_cnt - d0, a_valid);
        end
        b0 = nb; d0 = done_cnt;
        pulse_a();
        wait_a_done(d0, 100, ok);
        total++;
        if (!ok || nb - b0 !== 18) begin bad++; $display("FAIL rst_replay: done=%0d beats=%0d want 1 18", ok, nb - b0); end
        for (int k = 0; k < 18; k++) begin
            total++;
            if (bd[b0+k] !== 16'(k - 9) || bc[b0+k] !== (k >= 9)) begin
                bad++; $display("FAIL rst_beat%0d: got d=%0d c=%0d want d=%0d", k, bd[b0+k], bc[b0+k], k - 9);
            end
        end
    endtask

    task automatic test_base_addr;
        int cnt = 0, enan = 0, derr = 0, lastcnt = 0, lastidx = -1, maxc = 0;
        int first_addr = -1, last_addr = -1;
        bit got_done = 1'b0;
        b_ready = 1'b1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        for (int i = 0; i < 8000 && !got_done; i++) begin
            @(negedge clk);
            if (b_ena) begin
                if (first_addr < 0) first_addr = int'(b_addr);
                last_addr = int'(b_addr);
                enan++;
            end
            if (b_valid && b_ready) begin
                if (b_data !== 16'(cnt)) derr++;
                if (int'(b_chan) > maxc) maxc = int'(b_chan);
                if (b_last) begin lastcnt++; lastidx = cnt; end
                cnt++;
            end
            if (b_done) got_done = 1'b1;
        end
        total++;
        if (!got_done) begin bad++; $display("FAIL base_timeout: no done within 8000 cycles"); end
        total++;
        if (first_addr !== 100 || last_addr !== 7843) begin
            bad++; $display("FAIL base_addr: first=%0d last=%0d want 100 7843", first_addr, last_addr);
        end
        total++;
        if (cnt !== 7744 || enan !== 7744) begin bad++; $display("FAIL base_beats: beats=%0d reads=%0d want 7744", cnt, enan); end
        total++;
        if (derr !== 0) begin bad++; $display("FAIL base_data: got %0d wrong words want 0", derr); end
        total++;
        if (maxc !== 15) begin bad++; $display("FAIL base_chan: got max %0d want 15", maxc); end
        total++;
        if (lastcnt !== 1 || lastidx !== 7743) begin
            bad++; $display("FAIL base_last: count=%0d at=%0d want 1 7743", lastcnt, lastidx);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall20();
        test_double_start();
        test_mid_reset();
        test_base_addr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_result_reader.md
Name: conv_result_reader

Overview:
- Read-side companion to the convolution engine's result BRAM writer.
- After `conv_done`, walks the result BRAM port A linearly from `BASE_ADDR` and streams every stored result out on a valid/ready interface, tagged with its kernel channel and an end-of-frame marker.
- Hides the BRAM's 1-cycle read latency behind a 2-entry output buffer, so full throughput is kept under back-pressure.
- Sits beside the result BRAM on the BRAM's second port, or time-shared with the engine after completion.

Parameters:
- I_SIZE, 24, input feature-map side length.
- K_SIZE, 3, kernel side length; output side O_SIZE = I_SIZE-K_SIZE+1 (local constant).
- K_CHANNELS, 16, number of output channels; total words N = K_CHANNELS*O_SIZE*O_SIZE (7744 at defaults).
- O_BIT_WIDTH, 16, result word width, equal to the result BRAM data width.
- BASE_ADDR, 0, first result BRAM address.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a read-out (wired to `conv_done`).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- result_bram_ena  out  1  BRAM port enable; one read per asserted cycle.
- result_bram_addra  out  16  BRAM read address.
- result_bram_douta  in  O_BIT_WIDTH  BRAM read data, valid 1 cycle after ena.
- m_data  out  O_BIT_WIDTH  result word, signed.
- m_chan  out  max(1,$clog2(K_CHANNELS))  channel index of m_data.
- m_last  out  1  high on the final word (index N-1).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; a beat transfers when m_valid && m_ready.

Behaviour:
- Reset: clk and rstn only; reset is synchronous and active-low.
  - While rstn=0 at a rising edge: busy, done, result_bram_ena, m_valid, m_last all 0; result_bram_addra=BASE_ADDR; m_data=0; m_chan=0.
  - Buffer is emptied, inflight cleared, counters zeroed, state=IDLE.
- Reset mid-operation: abandons the frame immediately, with no done pulse. Any BRAM word returning the next cycle is discarded.
- States: IDLE, READ, DRAIN, DONE.
  - IDLE: on start=1 go to READ; rd_idx=0, addr=BASE_ADDR.
  - READ: issues reads. When the read for index N-1 is issued, go to DRAIN.
  - DRAIN: no reads. When the beat with m_last is accepted, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE, 1 in READ and DRAIN; busy is 0 in DONE.
- start while not IDLE is ignored. start in the DONE cycle is ignored.
- Read issue:
  - inflight is a 1-bit register, set in the cycle ena is asserted.
  - Occupancy occ (0..2) counts buffer entries.
  - ena=1 in READ when occ + inflight - (m_valid && m_ready) < 2.
  - On each issue, addr increments by 1.
  - The returning word is pushed at the next edge together with its chan and last tags, computed at issue time.
- Channel tag: a per-channel position counter wraps at O_SIZE*O_SIZE-1, and m_chan increments at that wrap. The index order is addr - BASE_ADDR = ch*O_SIZE^2 + row*O_SIZE + col.
- Output buffer:
  - 2-entry FIFO; m_data, m_chan and m_last come from the head; m_valid = (occ != 0).
  - Simultaneous push and pop keeps occ unchanged.
  - Ordering is strictly preserved; the buffer never overflows (guaranteed by the issue rule).
- Throughput: with m_ready held high, 1 beat per cycle after a 2-cycle start-up.
  - start accepted at edge t → ena=1 in cycle t+1 → first m_valid in cycle t+2.
- Stability: m_data, m_chan and m_last are held while m_valid && !m_ready.
- Arithmetic: counters wide enough for N-1; rd_idx 16 bits. Address wrap beyond 16 bits is not supported; an elaboration check enforces BASE_ADDR+N <= 65536.

Decomposition:
- Shared package conv_pkg holds:
  - O_SIZE function;
  - total-word-count function;
  - state encoding localparams (IDLE=0, READ=1, DRAIN=2, DONE=3);
  - the channel-width function.
- One natural sub-module, stream_fifo2: a 2-entry synchronous FIFO with push/pop/occ.
- The address generator and FSM stay in the top.

Test Plan:
- Small config (I_SIZE=5, K_SIZE=3, K_CHANNELS=2 → N=18), BRAM model with mem[i]=i-9, m_ready=1, start pulse → 18 beats on consecutive cycles:
  - m_data -9..8;
  - m_chan 0 for beats 0-8 and 1 for beats 9-17;
  - m_last only on beat 17;
  - done one cycle after beat 17; ena high exactly 18 cycles.
- Back-pressure: m_ready pattern 1,0,0,1,0,1… over the full frame → no lost or duplicated word, data stable while stalled, occ never above 2.
- m_ready=0 for 20 cycles after start → exactly 2 reads issued, m_valid held with m_data=-9; on release the stream resumes in order.
- Second start pulse mid-frame at beat 5 → ignored; exactly 18 beats and one done pulse.
- rstn=0 for one cycle at beat 7 with a read in flight → next cycle all outputs at reset values, no done; a fresh start replays from beat 0 correctly.
- BASE_ADDR=100 at defaults → first ena address 100, last address 7843, 7744 beats, m_chan reaches 15.
